// File: rtl/fwd_manchester_encoder_pkg.sv
// Shared types and constants for the forward Manchester re-encoder.
// FSM state enum, half-bit counter width and the fallback half-bit length.
package fwd_manchester_encoder_pkg;

  localparam int HALF_W = 6;
  localparam logic [HALF_W-1:0] DEFAULT_HALF_C = 6'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } enc_state_e;

  // Measured widths below 2 are unusable as a half-bit length, so use the fallback.
  function automatic logic [HALF_W-1:0] half_len(input logic [HALF_W-1:0] meas,
                                                 input logic [HALF_W-1:0] dflt);
    return (meas < HALF_W'(2)) ? dflt : meas;
  endfunction

endpackage

// File: rtl/fwd_manchester_encoder_bit_fifo.sv
// fwd_bit_fifo: synchronous single-bit FIFO with simultaneous push/pop,
// accepting a push while full when a pop happens in the same cycle.
module fwd_bit_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LVL_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/fwd_manchester_encoder.sv
// Forward Manchester re-encoder: queues qualified bits and replays each as two half-bit periods.
// Define FWD_ENCODER_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module fwd_manchester_encoder
  import fwd_manchester_encoder_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 4,
  parameter logic              IDLE_LEVEL   = 1'b0,
  parameter logic [HALF_W-1:0] DEFAULT_HALF = DEFAULT_HALF_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data,
  input  logic              in_clk,
  input  logic              in_sync,
  input  logic              in_forward,
  input  logic              in_invert,
  input  logic [HALF_W-1:0] half_period,
  output logic              out,
  output logic              out_busy,
  output logic              out_overflow,
  output logic [2:0]        out_level
);
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be 2 or 4 to fit the 3-bit level output");
  end

  enc_state_e        state_q, state_d;
  logic [HALF_W-1:0] cnt_q, cnt_d, half_q, half_d, half_m1;
  logic              bit_q, bit_d, out_q, out_d, busy_q, busy_d;
  logic              ovf_q, ovf_d, sync_q;
  logic              push_req, push_bit, pop, start, drop;
  logic              f_dout, f_full, f_empty;
  logic [2:0]        f_level;

  assign push_req = in_clk && in_sync && in_forward;
  assign push_bit = in_data ^ in_invert;

`ifdef FWD_ENCODER_FIFO_EN
  fwd_bit_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(3)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (push_bit),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level)
  );
`else
  logic hold_q, hold_d, hold_vld_q, hold_vld_d;

  // Occupancy is the only control here; the held bit itself is never reset.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop) hold_vld_d = 1'b0;
    if (push_req && (!hold_vld_q || pop)) begin
      hold_vld_d = 1'b1;
      hold_d     = push_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_vld_q <= 1'b0;
    else     hold_vld_q <= hold_vld_d;
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign f_dout  = hold_q;
  assign f_full  = hold_vld_q;
  assign f_empty = !hold_vld_q;
  assign f_level = {2'b00, hold_vld_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    out_d   = out_q;
    pop     = 1'b0;
    start   = 1'b0;
    half_m1 = half_len(half_period, DEFAULT_HALF) - HALF_W'(1);
    unique case (state_q)
      IDLE: start = !f_empty;
      FIRST: begin
        if (cnt_q == '0) begin
          cnt_d   = half_q;
          out_d   = bit_q;
          state_d = SECOND;
        end else begin
          cnt_d = cnt_q - HALF_W'(1);
        end
      end
      SECOND: begin
        if (cnt_q == '0) begin
          if (!f_empty) begin
            start = 1'b1;
          end else begin
            out_d   = IDLE_LEVEL;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - HALF_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Starting a bit pops it and samples the half length so SECOND reuses the same value.
    if (start) begin
      pop     = 1'b1;
      bit_d   = f_dout;
      half_d  = half_m1;
      cnt_d   = half_m1;
      out_d   = ~f_dout;
      state_d = FIRST;
    end
    drop   = push_req && f_full && !pop;
    ovf_d  = (ovf_q && !(in_sync && !sync_q)) || drop;
    busy_d = (state_d != IDLE) || (!f_empty && !pop) || push_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      sync_q  <= in_sync;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    half_q <= half_d;
    bit_q  <= bit_d;
  end

  assign out          = out_q;
  assign out_busy     = busy_q;
  assign out_overflow = ovf_q;
  assign out_level    = f_level;

endmodule
